// File: rtl/pipe_stage_bank.sv
// pipe_stage_bank: N-stage pipeline register bank (clk, async active-low reset_n; in_valid/in_data/in_halt -> in_ready; stall_vec/flush_vec control; stage_valid/stage_data view; retire_valid/retire_data/num_inst/is_halted; PIPE_PERF_EN adds perf_stall_cnt/perf_flush_cnt)
module pipe_stage_bank #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_halt,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stall_vec,
  input  logic [STAGES-1:0]        flush_vec,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic                     retire_valid,
  output logic [DATA_W-1:0]        retire_data,
  output logic [CNT_W-1:0]         num_inst,
  output logic                     is_halted
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]         perf_stall_cnt,
  output logic [CNT_W-1:0]         perf_flush_cnt
`endif
);
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [STAGES-1:0] valid_d, tag_q, tag_d, kill;
  logic accept;
  int s, f;
  assign in_ready = ~is_halted & ~|stall_vec & ~|flush_vec;
  assign accept = in_valid & in_ready;
  assign retire_valid = stage_valid[STAGES-1] & ~is_halted & ~stall_vec[STAGES-1] & ~flush_vec[STAGES-1];
  assign retire_data = data_q[STAGES-1];
  for (genvar g = 0; g < STAGES; g++) begin : g_view
    assign stage_data[g*DATA_W +: DATA_W] = data_q[g];
  end
  always_comb begin
    s = -1;
    f = -1;
    for (int i = 0; i < STAGES; i++) begin
      s = stall_vec[i] ? i : s;
      f = flush_vec[i] ? i : f;
    end
    for (int i = 0; i < STAGES; i++) kill[i] = ~is_halted & (i <= f);
  end
  always_comb begin
    valid_d = stage_valid;
    tag_d = tag_q;
    data_d = data_q;
    if (kill[0]) begin
      valid_d[0] = 1'b0;
      tag_d[0] = 1'b0;
    end else if (!is_halted && s < 0) begin
      valid_d[0] = accept;
      tag_d[0] = accept ? in_halt : tag_q[0];
      data_d[0] = accept ? in_data : data_q[0];
    end
    for (int i = 1; i < STAGES; i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
        tag_d[i] = 1'b0;
      end else if (!is_halted && i > s) begin
        valid_d[i] = (i == s + 1) ? 1'b0 : stage_valid[i-1];
        tag_d[i] = (i == s + 1) ? 1'b0 : tag_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= '0;
      tag_q <= '0;
      data_q <= '{default: '0};
      num_inst <= '0;
      is_halted <= 1'b0;
    end else begin
      stage_valid <= valid_d;
      tag_q <= tag_d;
      data_q <= data_d;
      num_inst <= num_inst + CNT_W'(retire_valid);
      is_halted <= is_halted | (retire_valid & tag_q[STAGES-1]);
    end
  end
`ifdef PIPE_PERF_EN
  logic [CNT_W:0] flush_sum;
  always_comb begin
    flush_sum = {1'b0, perf_flush_cnt};
    for (int i = 0; i < STAGES; i++) flush_sum = flush_sum + (CNT_W+1)'(kill[i] & stage_valid[i]);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + CNT_W'(|stall_vec & ~is_halted & ~&perf_stall_cnt);
      perf_flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_bank.sv
// tb_pipe_stage_bank: directed and randomized checks of pipe_stage_bank against a behavioural model
module tb_pipe_stage_bank;
  localparam int DW = 16;
  localparam int ST = 4;
  localparam int CW = 16;
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_halt = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [ST-1:0] stall_vec = '0, flush_vec = '0;
  logic in_ready, retire_valid, is_halted;
  logic [ST-1:0] stage_valid;
  logic [ST*DW-1:0] stage_data;
  logic [DW-1:0] retire_data;
  logic [CW-1:0] num_inst;
  logic w_ready, w_rv, w_halt;
  logic [ST-1:0] w_sv;
  logic [ST*DW-1:0] w_sd;
  logic [DW-1:0] w_rd;
  logic [3:0] w_num;
`ifdef PIPE_PERF_EN
  logic [CW-1:0] ps, pf;
  logic [3:0] w_ps, w_pf;
`endif
  int checks = 0, passes = 0;
  bit mv [ST];
  bit mt [ST];
  logic [DW-1:0] md [ST];
  int mcnt, mps, mpf;
  bit mh;

  pipe_stage_bank #(.DATA_W(DW), .STAGES(ST), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_halt(in_halt),
    .in_ready(in_ready), .stall_vec(stall_vec), .flush_vec(flush_vec), .stage_valid(stage_valid),
    .stage_data(stage_data), .retire_valid(retire_valid), .retire_data(retire_data),
    .num_inst(num_inst), .is_halted(is_halted)
`ifdef PIPE_PERF_EN
    , .perf_stall_cnt(ps), .perf_flush_cnt(pf)
`endif
  );

  pipe_stage_bank #(.DATA_W(DW), .STAGES(ST), .CNT_W(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_halt(in_halt),
    .in_ready(w_ready), .stall_vec(stall_vec), .flush_vec(flush_vec), .stage_valid(w_sv),
    .stage_data(w_sd), .retire_valid(w_rv), .retire_data(w_rd),
    .num_inst(w_num), .is_halted(w_halt)
`ifdef PIPE_PERF_EN
    , .perf_stall_cnt(w_ps), .perf_flush_cnt(w_pf)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < ST; i++) begin
      mv[i] = 0;
      mt[i] = 0;
      md[i] = '0;
    end
    mcnt = 0; mps = 0; mpf = 0; mh = 0;
  endfunction

  function automatic bit exp_ready();
    return !mh && stall_vec == 0 && flush_vec == 0;
  endfunction

  function automatic bit exp_retire();
    return mv[ST-1] && !mh && !stall_vec[ST-1] && !flush_vec[ST-1];
  endfunction

  function automatic logic [ST-1:0] exp_valid();
    logic [ST-1:0] v;
    for (int i = 0; i < ST; i++) v[i] = mv[i];
    return v;
  endfunction

  function automatic int sat(int v, int m);
    return v > m ? m : v;
  endfunction

  // Applies one clock edge to the model using the inputs currently driven.
  function automatic void model_edge();
    int s, f;
    bit rdy;
    s = -1;
    f = -1;
    rdy = exp_ready();
    if (mh) return;
    for (int i = 0; i < ST; i++) begin
      if (stall_vec[i]) s = i;
      if (flush_vec[i]) f = i;
    end
    if (exp_retire()) begin
      mcnt++;
      if (mt[ST-1]) mh = 1;
    end
    if (stall_vec != 0) mps++;
    for (int i = 0; i <= f; i++) if (mv[i]) mpf++;
    for (int i = ST - 1; i >= 0; i--) begin
      if (i <= f) begin
        mv[i] = 0;
        mt[i] = 0;
      end else if (i > s) begin
        if (s >= 0 && i == s + 1) mv[i] = 0;
        else if (i == 0) begin
          mv[0] = in_valid && rdy;
          if (mv[0]) begin
            md[0] = in_data;
            mt[0] = in_halt;
          end
        end else begin
          mv[i] = mv[i-1];
          mt[i] = mt[i-1];
          md[i] = md[i-1];
        end
      end
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_halt = 0; stall_vec = '0; flush_vec = '0;
    reset_n = 0;
    #2;
    reset_n = 1;
    model_clear();
  endtask

  task automatic fill(int n);
    for (int k = 1; k <= n; k++) begin
      in_valid = 1;
      in_data = DW'(k);
      step();
    end
    in_valid = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (stage_valid !== '0) $display("FAIL reset_valid: got %b want 0", stage_valid); else passes++;
    checks++; if (stage_data !== '0) $display("FAIL reset_data: got %h want 0", stage_data); else passes++;
    checks++; if (num_inst !== '0) $display("FAIL reset_num: got %0d want 0", num_inst); else passes++;
    checks++; if (is_halted !== 1'b0) $display("FAIL reset_halt: got %b want 0", is_halted); else passes++;
    reset_n = 1;
    model_clear();
  endtask

  task automatic test_stream();
    int got = 1;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      in_valid = k <= 8;
      in_data = DW'(k);
      #1;
      checks++; if (retire_valid !== exp_retire()) $display("FAIL stream_rv k=%0d: got %b want %b", k, retire_valid, exp_retire()); else passes++;
      if (retire_valid) begin
        checks++; if (retire_data !== DW'(got)) $display("FAIL stream_order: got %0d want %0d", retire_data, got); else passes++;
        got++;
      end
      step();
      if (k == 4) begin
        checks++; if (stage_valid[3] !== 1'b1 || stage_data[3*DW +: DW] !== DW'(1)) $display("FAIL stream_latency: got v=%b d=%0d want v=1 d=1", stage_valid[3], stage_data[3*DW +: DW]); else passes++;
      end
    end
    in_valid = 0;
    checks++; if (got != 9) $display("FAIL stream_count: got %0d retires want 8", got - 1); else passes++;
    checks++; if (num_inst !== CW'(8)) $display("FAIL stream_num: got %0d want 8", num_inst); else passes++;
  endtask

  task automatic test_stall();
    int nxt = 5, got = 1;
    do_reset();
    fill(4);
    checks++; if (stage_valid !== 4'b1111) $display("FAIL stall_full: got %b want 1111", stage_valid); else passes++;
    stall_vec = 4'b0010;
    in_valid = 1;
    in_data = DW'(nxt);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", in_ready); else passes++;
      if (retire_valid) begin
        checks++; if (retire_data !== DW'(got)) $display("FAIL stall_order: got %0d want %0d", retire_data, got); else passes++;
        got++;
      end
      step();
      checks++; if (stage_valid !== (k == 0 ? 4'b1011 : 4'b0011)) $display("FAIL stall_valid k=%0d: got %b want %b", k, stage_valid, exp_valid()); else passes++;
      checks++; if (stage_data[0 +: 2*DW] !== {DW'(3), DW'(4)}) $display("FAIL stall_hold: got %h want 00030004", stage_data[0 +: 2*DW]); else passes++;
    end
    stall_vec = '0;
    for (int k = 0; k < 12; k++) begin
      in_valid = nxt <= 8;
      in_data = DW'(nxt);
      #1;
      if (retire_valid) begin
        checks++; if (retire_data !== DW'(got)) $display("FAIL stall_order: got %0d want %0d", retire_data, got); else passes++;
        got++;
      end
      if (in_valid && in_ready) nxt++;
      step();
    end
    in_valid = 0;
    checks++; if (got != 9) $display("FAIL stall_count: got %0d retires want 8", got - 1); else passes++;
    checks++; if (num_inst !== CW'(8)) $display("FAIL stall_num: got %0d want 8", num_inst); else passes++;
  endtask

  task automatic test_flush();
    do_reset();
    fill(4);
    flush_vec = 4'b0100;
    #1;
    checks++; if (retire_valid !== 1'b1 || retire_data !== DW'(1)) $display("FAIL flush_retire: got v=%b d=%0d want v=1 d=1", retire_valid, retire_data); else passes++;
    step();
    flush_vec = '0;
    checks++; if (stage_valid !== 4'b1000) $display("FAIL flush_valid: got %b want 1000", stage_valid); else passes++;
    checks++; if (stage_data[3*DW +: DW] !== DW'(2)) $display("FAIL flush_reg3: got %0d want 2", stage_data[3*DW +: DW]); else passes++;
    checks++; if (num_inst !== CW'(1)) $display("FAIL flush_num: got %0d want 1", num_inst); else passes++;
`ifdef PIPE_PERF_EN
    checks++; if (pf !== CW'(3)) $display("FAIL flush_perf: got %0d want 3", pf); else passes++;
`endif
    step();
    checks++; if (num_inst !== CW'(2) || stage_valid !== '0) $display("FAIL flush_drain: got n=%0d v=%b want n=2 v=0", num_inst, stage_valid); else passes++;
  endtask

  task automatic test_flush_stall();
    do_reset();
    fill(3);
    flush_vec = 4'b0001;
    stall_vec = 4'b0100;
    #1;
    checks++; if (retire_valid !== 1'b0) $display("FAIL fs_retire: got %b want 0", retire_valid); else passes++;
    step();
    flush_vec = '0;
    stall_vec = '0;
    checks++; if (stage_valid !== 4'b0110) $display("FAIL fs_valid: got %b want 0110", stage_valid); else passes++;
    checks++; if (stage_data[DW +: 2*DW] !== {DW'(1), DW'(2)}) $display("FAIL fs_hold: got %h want 00010002", stage_data[DW +: 2*DW]); else passes++;
    checks++; if (num_inst !== '0) $display("FAIL fs_num: got %0d want 0", num_inst); else passes++;
`ifdef PIPE_PERF_EN
    checks++; if (ps !== CW'(1) || pf !== CW'(1)) $display("FAIL fs_perf: got s=%0d f=%0d want s=1 f=1", ps, pf); else passes++;
`endif
  endtask

  task automatic test_halt();
    do_reset();
    in_valid = 1;
    for (int k = 1; k <= 9; k++) begin
      in_data = DW'(k);
      in_halt = k == 5;
      step();
      checks++; if (is_halted !== (k == 9)) $display("FAIL halt_flag k=%0d: got %b want %b", k, is_halted, k == 9); else passes++;
    end
    in_halt = 0;
    checks++; if (num_inst !== CW'(5)) $display("FAIL halt_num: got %0d want 5", num_inst); else passes++;
    for (int k = 0; k < 5; k++) begin
      in_data = DW'($urandom);
      stall_vec = ST'($urandom);
      flush_vec = ST'($urandom);
      #1;
      checks++; if (in_ready !== 1'b0 || retire_valid !== 1'b0) $display("FAIL halt_out: got r=%b rv=%b want 0 0", in_ready, retire_valid); else passes++;
      step();
      checks++; if (num_inst !== CW'(5) || is_halted !== 1'b1) $display("FAIL halt_hold: got n=%0d h=%b want 5 1", num_inst, is_halted); else passes++;
      checks++; if (stage_valid !== 4'b1111 || stage_data[3*DW +: DW] !== DW'(6)) $display("FAIL halt_freeze: got v=%b d=%0d want 1111 6", stage_valid, stage_data[3*DW +: DW]); else passes++;
    end
    in_valid = 0; stall_vec = '0; flush_vec = '0;
  endtask

  task automatic test_flush_halt();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1;
      in_data = DW'(k);
      in_halt = k == 1;
      step();
    end
    in_valid = 0;
    in_halt = 0;
    flush_vec = 4'b1000;
    #1;
    checks++; if (retire_valid !== 1'b0) $display("FAIL fh_retire: got %b want 0", retire_valid); else passes++;
    step();
    flush_vec = '0;
    checks++; if (stage_valid !== '0) $display("FAIL fh_valid: got %b want 0", stage_valid); else passes++;
`ifdef PIPE_PERF_EN
    checks++; if (pf !== CW'(4)) $display("FAIL fh_perf: got %0d want 4", pf); else passes++;
`endif
    for (int k = 0; k < 5; k++) step();
    checks++; if (is_halted !== 1'b0 || num_inst !== '0 || in_ready !== 1'b1) $display("FAIL fh_state: got h=%b n=%0d r=%b want 0 0 1", is_halted, num_inst, in_ready); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    fill(6);
    #2;
    reset_n = 0;
    #1;
    checks++; if (stage_valid !== '0 || w_sv !== '0) $display("FAIL areset_valid: got %b want 0", stage_valid); else passes++;
    checks++; if (stage_data !== '0) $display("FAIL areset_data: got %h want 0", stage_data); else passes++;
    checks++; if (num_inst !== '0 || w_num !== '0) $display("FAIL areset_num: got %0d want 0", num_inst); else passes++;
    checks++; if (retire_valid !== 1'b0 || is_halted !== 1'b0) $display("FAIL areset_out: got rv=%b h=%b want 0 0", retire_valid, is_halted); else passes++;
    #2;
    reset_n = 1;
    model_clear();
    step();
    checks++; if (stage_valid !== '0) $display("FAIL areset_after: got %b want 0", stage_valid); else passes++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 1; k <= 21; k++) begin
      in_valid = k <= 17;
      in_data = DW'(k);
      step();
    end
    in_valid = 0;
    checks++; if (num_inst !== CW'(17)) $display("FAIL wrap_num16: got %0d want 17", num_inst); else passes++;
    checks++; if (w_num !== 4'd1) $display("FAIL wrap_num4: got %0d want 1", w_num); else passes++;
  endtask

  task automatic test_random();
    int hcyc = 0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = DW'($urandom);
      in_halt = $urandom_range(0, 39) == 0;
      stall_vec = ($urandom_range(0, 4) == 0) ? ST'($urandom) : '0;
      flush_vec = ($urandom_range(0, 7) == 0) ? ST'($urandom) : '0;
      #1;
      checks++; if (in_ready !== exp_ready()) $display("FAIL rnd_ready n=%0d: got %b want %b", n, in_ready, exp_ready()); else passes++;
      checks++; if (retire_valid !== exp_retire()) $display("FAIL rnd_rv n=%0d: got %b want %b", n, retire_valid, exp_retire()); else passes++;
      if (exp_retire()) begin
        checks++; if (retire_data !== md[ST-1]) $display("FAIL rnd_rd n=%0d: got %h want %h", n, retire_data, md[ST-1]); else passes++;
      end
      step();
      checks++; if (stage_valid !== exp_valid()) $display("FAIL rnd_valid n=%0d: got %b want %b", n, stage_valid, exp_valid()); else passes++;
      for (int i = 0; i < ST; i++) if (mv[i]) begin
        checks++; if (stage_data[i*DW +: DW] !== md[i]) $display("FAIL rnd_data n=%0d reg%0d: got %h want %h", n, i, stage_data[i*DW +: DW], md[i]); else passes++;
      end
      checks++; if (num_inst !== CW'(mcnt) || w_num !== 4'(mcnt)) $display("FAIL rnd_num n=%0d: got %0d/%0d want %0d", n, num_inst, w_num, mcnt); else passes++;
      checks++; if (is_halted !== mh) $display("FAIL rnd_halt n=%0d: got %b want %b", n, is_halted, mh); else passes++;
`ifdef PIPE_PERF_EN
      checks++; if (ps !== CW'(sat(mps, 65535)) || w_ps !== 4'(sat(mps, 15))) $display("FAIL rnd_pstall n=%0d: got %0d/%0d want %0d", n, ps, w_ps, mps); else passes++;
      checks++; if (pf !== CW'(sat(mpf, 65535)) || w_pf !== 4'(sat(mpf, 15))) $display("FAIL rnd_pflush n=%0d: got %0d/%0d want %0d", n, pf, w_pf, mpf); else passes++;
`endif
      hcyc = mh ? hcyc + 1 : 0;
      if (hcyc > 4) begin
        do_reset();
        hcyc = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_stall();
    test_halt();
    test_flush_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
